// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response bus between fetch and imem.
// Request held with stable address until granted; responses return in order.
interface fetch_stage_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_gnt,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_gnt,
        output imem_rvalid,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_stage.sv
// RV32I fetch stage: owns fetch PC, one outstanding imem request,
// 2-entry instruction FIFO feeding IF/ID, stall and redirect handling.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic          clk,
    input  logic          rst,
    fetch_stage_if.master imem,
    input  logic          Stall,
    input  logic          PCSrcE,
    input  logic [31:0]   PCTargetE,
    output logic [31:0]   InstrF,
    output logic [31:0]   PCF,
    output logic [31:0]   PCPlus4F,
    output logic          FetchValid
);

    typedef enum logic [1:0] {
        FETCH,
        WAIT,
        DRAIN
    } state_t;

    state_t      state;
    state_t      state_nx;
    logic [31:0] fetch_pc;
    logic [31:0] req_pc;
    logic [31:0] fifo_instr [2];
    logic [31:0] fifo_pc [2];
    logic        rd_ptr;
    logic        wr_ptr;
    logic [1:0]  count;
    logic        pop;
    logic        push;
    logic        grant;
    logic [1:0]  occ_next;

    always_comb begin
        pop      = (count != 2'd0) && !Stall && !PCSrcE;
        push     = (state == WAIT) && imem.imem_rvalid && !PCSrcE;
        occ_next = count - {1'b0, pop} + {1'b0, push};
        imem.imem_req = !rst && !PCSrcE && (occ_next <= 2'd1) &&
                        ((state == FETCH) ||
                         ((state == WAIT) && imem.imem_rvalid));
        imem.imem_addr = fetch_pc;
        grant = imem.imem_req && imem.imem_gnt;
    end

    always_comb begin
        state_nx = state;
        case (state)
            FETCH: begin
                if (grant)
                    state_nx = WAIT;
            end
            WAIT: begin
                if (imem.imem_rvalid)
                    state_nx = grant ? WAIT : FETCH;
                else if (PCSrcE)
                    state_nx = DRAIN;
            end
            DRAIN: begin
                if (imem.imem_rvalid)
                    state_nx = FETCH;
            end
            default: state_nx = FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= FETCH;
            fetch_pc <= RESET_PC;
            req_pc   <= RESET_PC;
            count    <= 2'd0;
            rd_ptr   <= 1'b0;
            wr_ptr   <= 1'b0;
        end else begin
            state <= state_nx;
            // Redirect target is forced word aligned
            if (PCSrcE)
                fetch_pc <= PCTargetE & 32'hFFFF_FFFC;
            else if (grant)
                fetch_pc <= fetch_pc + 32'd4;
            if (grant)
                req_pc <= fetch_pc;
            if (PCSrcE) begin
                count  <= 2'd0;
                rd_ptr <= 1'b0;
                wr_ptr <= 1'b0;
            end else begin
                count <= occ_next;
                if (push)
                    wr_ptr <= ~wr_ptr;
                if (pop)
                    rd_ptr <= ~rd_ptr;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_instr[wr_ptr] <= imem.imem_rdata;
            fifo_pc[wr_ptr]    <= req_pc;
        end
    end

    always_comb begin
        FetchValid = (count != 2'd0);
        InstrF     = FetchValid ? fifo_instr[rd_ptr] : NOP_INSTR;
        PCF        = FetchValid ? fifo_pc[rd_ptr] : 32'd0;
        PCPlus4F   = FetchValid ? fifo_pc[rd_ptr] + 32'd4 : 32'd0;
    end

    a_no_overflow: assert property (
        @(posedge clk) disable iff (rst) !(push && (count == 2'd2))
    );

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: imem model returning addr as data,
// grant-order scoreboard plus directed stall/redirect/reset/wrap checks.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        pcsrc = 1'b0;
    logic [31:0] target = 32'd0;
    logic        gnt_en = 1'b1;
    int          lat = 1;

    logic [31:0] instr, pc, pc4;
    logic        valid;
    logic [31:0] instr2, pc2, pc42;
    logic        valid2;

    int n_chk = 0;
    int n_pass = 0;

    fetch_stage_if bus ();
    fetch_stage_if bus2 ();

    fetch_stage dut (
        .clk        (clk),
        .rst        (rst),
        .imem       (bus),
        .Stall      (stall),
        .PCSrcE     (pcsrc),
        .PCTargetE  (target),
        .InstrF     (instr),
        .PCF        (pc),
        .PCPlus4F   (pc4),
        .FetchValid (valid)
    );

    fetch_stage #(.RESET_PC(32'hFFFF_FFF8)) dut2 (
        .clk        (clk),
        .rst        (rst),
        .imem       (bus2),
        .Stall      (1'b0),
        .PCSrcE     (1'b0),
        .PCTargetE  (32'd0),
        .InstrF     (instr2),
        .PCF        (pc2),
        .PCPlus4F   (pc42),
        .FetchValid (valid2)
    );

    always #5 clk = ~clk;

    // Memory model for the main DUT: programmable grant and latency
    logic        pend = 1'b0;
    logic [31:0] paddr = 32'd0;
    int          wcnt = 0;

    assign bus.imem_gnt    = gnt_en;
    assign bus.imem_rvalid = pend && (wcnt == 0);
    assign bus.imem_rdata  = pend ? paddr : 32'hDEAD_BEEF;

    always @(posedge clk) begin
        if (bus.imem_rvalid)
            pend <= 1'b0;
        if (bus.imem_req && bus.imem_gnt) begin
            pend  <= 1'b1;
            paddr <= bus.imem_addr;
            wcnt  <= lat - 1;
        end else if (pend && wcnt > 0) begin
            wcnt <= wcnt - 1;
        end
    end

    // Zero-wait memory for the wrap instance
    logic        rv2 = 1'b0;
    logic [31:0] rd2 = 32'd0;

    assign bus2.imem_gnt    = 1'b1;
    assign bus2.imem_rvalid = rv2;
    assign bus2.imem_rdata  = rd2;

    always @(posedge clk) begin
        rv2 <= bus2.imem_req;
        rd2 <= bus2.imem_addr;
    end

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    // Scoreboard: granted addresses in order; a redirect or reset
    // kills everything granted so far.
    logic [31:0] exp_q[$];

    always @(negedge clk) begin
        logic [31:0] e;
        if (rst || pcsrc) begin
            exp_q.delete();
        end else begin
            if (valid && !stall) begin
                if (exp_q.size() == 0) begin
                    check("sb_underflow", 32'(exp_q.size()), 32'd1);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_instr", instr, e);
                    check("sb_pc", pc, e);
                    check("sb_pc4", pc4, e + 32'd4);
                end
            end
            if (bus.imem_req && bus.imem_gnt)
                exp_q.push_back(bus.imem_addr);
        end
    end

    task automatic nxt();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset(input int l);
        rst = 1'b1;
        stall = 1'b0;
        pcsrc = 1'b0;
        gnt_en = 1'b1;
        lat = l;
        nxt();
        check("rst_instr", instr, NOP);
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_req", 32'(bus.imem_req), 32'd0);
        nxt();
        rst = 1'b0;
        #1;
    endtask

    task automatic wait_valid(input string tag);
        int k;
        k = 0;
        while (!valid && k < 10) begin
            nxt();
            k++;
        end
        check(tag, 32'(valid), 32'd1);
    endtask

    initial begin
        // Zero-wait streaming plus wrap instance
        do_reset(1);
        check("addr0", bus.imem_addr, 32'h0);
        check("req0", 32'(bus.imem_req), 32'd1);
        check("w_addr0", bus2.imem_addr, 32'hFFFF_FFF8);
        nxt();
        check("addr1", bus.imem_addr, 32'h4);
        check("nop_lead", instr, NOP);
        check("w_addr1", bus2.imem_addr, 32'hFFFF_FFFC);
        nxt();
        check("first_instr", instr, 32'h0);
        check("first_pc4", pc4, 32'h4);
        check("addr2", bus.imem_addr, 32'h8);
        check("w_addr2", bus2.imem_addr, 32'h0);
        check("w_instr0", instr2, 32'hFFFF_FFF8);
        nxt();
        check("instr1", instr, 32'h4);
        check("pc4_1", pc4, 32'h8);
        check("w_instr1", instr2, 32'hFFFF_FFFC);
        check("w_pc4_wrap", pc42, 32'h0);
        nxt();
        check("instr2", instr, 32'h8);
        check("pc4_2", pc4, 32'hC);
        check("w_instr2", instr2, 32'h0);

        // Stall holds head; FIFO fills to 2 and requests stop
        do_reset(1);
        nxt();
        nxt();
        check("stall_head", instr, 32'h0);
        stall = 1'b1;
        #1;
        check("stall_noreq0", 32'(bus.imem_req), 32'd0);
        for (int k = 0; k < 4; k++) begin
            nxt();
            check("stall_hold", instr, 32'h0);
            check("stall_noreq", 32'(bus.imem_req), 32'd0);
        end
        check("stall_count", 32'(dut.count), 32'd2);
        stall = 1'b0;
        nxt();
        check("post_stall0", instr, 32'h4);
        nxt();
        check("post_stall1", instr, 32'h8);

        // Grant withheld: address held, no skip
        gnt_en = 1'b0;
        for (int k = 0; k < 3; k++) begin
            nxt();
            check("nogrant_req", 32'(bus.imem_req), 32'd1);
            check("nogrant_addr", bus.imem_addr, 32'h10);
        end
        gnt_en = 1'b1;
        repeat (4) nxt();

        // Redirect while waiting, late response discarded
        do_reset(2);
        nxt();
        pcsrc = 1'b1;
        target = 32'h100;
        #1;
        check("redir_noreq", 32'(bus.imem_req), 32'd0);
        nxt();
        pcsrc = 1'b0;
        #1;
        check("drain_valid", 32'(valid), 32'd0);
        check("drain_nop", instr, NOP);
        check("drain_noreq", 32'(bus.imem_req), 32'd0);
        nxt();
        check("redir_req", 32'(bus.imem_req), 32'd1);
        check("redir_addr", bus.imem_addr, 32'h100);
        wait_valid("redir_timeout");
        check("redir_instr", instr, 32'h100);

        // Redirect with rvalid and stall, unaligned target
        do_reset(1);
        nxt();
        stall = 1'b1;
        pcsrc = 1'b1;
        target = 32'h203;
        #1;
        check("r2_noreq", 32'(bus.imem_req), 32'd0);
        nxt();
        stall = 1'b0;
        pcsrc = 1'b0;
        #1;
        check("r2_valid", 32'(valid), 32'd0);
        check("r2_addr", bus.imem_addr, 32'h200);
        check("r2_req", 32'(bus.imem_req), 32'd1);
        wait_valid("r2_timeout");
        check("r2_instr", instr, 32'h200);

        // Reset asserted mid-WAIT with a buffered instruction
        do_reset(1);
        nxt();
        nxt();
        check("mid_valid", 32'(valid), 32'd1);
        rst = 1'b1;
        #1;
        check("mid_instr", instr, NOP);
        check("mid_pc", pc, 32'd0);
        check("mid_pc4", pc4, 32'd0);
        check("mid_fv", 32'(valid), 32'd0);
        check("mid_req", 32'(bus.imem_req), 32'd0);
        nxt();
        nxt();
        rst = 1'b0;
        #1;
        check("restart_addr", bus.imem_addr, 32'h0);
        check("restart_req", 32'(bus.imem_req), 32'd1);
        check("w_restart", bus2.imem_addr, 32'hFFFF_FFF8);
        repeat (4) nxt();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1);
    end

endmodule
